// File: rtl/raycast_column_scheduler.sv
// Frame sequencer for the ray-cast engines: sweeps NUM_COLS columns, fires both wall engines,
// picks the nearer hit and streams one column record per ray. Optional macro: RAYCAST_TIMEOUT_EN.
module raycast_column_scheduler #(
  parameter int unsigned NUM_COLS   = 160,
  parameter int unsigned ANGLE_STEP = 5,
  parameter int unsigned ANGLE_FULL = 3600
`ifdef RAYCAST_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = 1024
`endif
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start_frame,
  input  logic [11:0]                 player_x,
  input  logic [11:0]                 player_y,
  input  logic [11:0]                 player_angle,
  output logic                        busy,
  output logic                        frame_done,
  output logic [11:0]                 ray_x,
  output logic [11:0]                 ray_y,
  output logic [11:0]                 ray_alpha,
  output logic                        begin_calc,
  input  logic                        h_end,
  input  logic                        v_end,
  input  logic                        h_found,
  input  logic                        v_found,
  input  logic [11:0]                 h_wx,
  input  logic [11:0]                 h_wy,
  input  logic [11:0]                 v_wx,
  input  logic [11:0]                 v_wy,
  output logic                        col_valid,
  input  logic                        col_ready,
  output logic [$clog2(NUM_COLS)-1:0] col_index,
  output logic [12:0]                 col_dist,
  output logic                        col_hit,
  output logic                        col_side,
  output logic [11:0]                 col_wx,
  output logic [11:0]                 col_wy,
  output logic                        ray_timeout
);

  localparam int unsigned CW      = $clog2(NUM_COLS);
  localparam int unsigned HALF    = (NUM_COLS * ANGLE_STEP) / 2;
  localparam logic [12:0] NO_DIST = 13'h1FFF;
`ifdef RAYCAST_TIMEOUT_EN
  localparam int unsigned TW      = $clog2(TIMEOUT_CYC);
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_ISSUE, S_WAIT, S_COMPARE, S_OUTPUT, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic            busy_q, busy_d;
  logic            frame_done_q, frame_done_d;
  logic            begin_calc_q, begin_calc_d;
  logic [11:0]     px_q, px_d, py_q, py_d;
  logic [11:0]     alpha_q, alpha_d;
  logic [CW-1:0]   col_q, col_d;
  logic            h_done_q, h_done_d, v_done_q, v_done_d;
  logic            h_found_q, h_found_d, v_found_q, v_found_d;
  logic [11:0]     h_wx_q, h_wx_d, h_wy_q, h_wy_d;
  logic [11:0]     v_wx_q, v_wx_d, v_wy_q, v_wy_d;
  logic            col_valid_q, col_valid_d;
  logic [12:0]     col_dist_q, col_dist_d;
  logic            col_hit_q, col_hit_d;
  logic            col_side_q, col_side_d;
  logic [11:0]     col_wx_q, col_wx_d, col_wy_q, col_wy_d;
  logic            ray_to_q, ray_to_d;
`ifdef RAYCAST_TIMEOUT_EN
  logic [TW-1:0]   tmo_q, tmo_d;
`endif

  logic [31:0]     start_sum_c, step_sum_c;
  logic [11:0]     alpha_start_c, alpha_next_c;
  logic [12:0]     h_dist_c, v_dist_c;
  logic            h_done_c, v_done_c, timeout_c;

  function automatic logic [12:0] manhattan(input logic [11:0] ax, input logic [11:0] ay,
                                            input logic [11:0] bx, input logic [11:0] by);
    logic [11:0] dx;
    logic [11:0] dy;
    dx = (ax >= bx) ? (ax - bx) : (bx - ax);
    dy = (ay >= by) ? (ay - by) : (by - ay);
    return 13'(dx) + 13'(dy);
  endfunction

  // Angles are biased by a full turn so the subtraction never goes negative.
  assign start_sum_c   = 32'(player_angle) + ANGLE_FULL - HALF;
  assign alpha_start_c = (start_sum_c >= ANGLE_FULL) ? 12'(start_sum_c - ANGLE_FULL)
                                                     : 12'(start_sum_c);
  assign step_sum_c    = 32'(alpha_q) + ANGLE_STEP;
  assign alpha_next_c  = (step_sum_c >= ANGLE_FULL) ? 12'(step_sum_c - ANGLE_FULL)
                                                    : 12'(step_sum_c);

  assign h_dist_c = manhattan(h_wx_q, h_wy_q, px_q, py_q);
  assign v_dist_c = manhattan(v_wx_q, v_wy_q, px_q, py_q);
  assign h_done_c = h_done_q | h_end;
  assign v_done_c = v_done_q | v_end;

`ifdef RAYCAST_TIMEOUT_EN
  assign timeout_c = (tmo_q == TW'(TIMEOUT_CYC - 1));
`else
  assign timeout_c = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    px_d        = px_q;
    py_d        = py_q;
    alpha_d     = alpha_q;
    col_d       = col_q;
    h_done_d    = h_done_q;
    v_done_d    = v_done_q;
    h_found_d   = h_found_q;
    v_found_d   = v_found_q;
    h_wx_d      = h_wx_q;
    h_wy_d      = h_wy_q;
    v_wx_d      = v_wx_q;
    v_wy_d      = v_wy_q;
    col_valid_d = col_valid_q;
    col_dist_d  = col_dist_q;
    col_hit_d   = col_hit_q;
    col_side_d  = col_side_q;
    col_wx_d    = col_wx_q;
    col_wy_d    = col_wy_q;
    ray_to_d    = ray_to_q;
`ifdef RAYCAST_TIMEOUT_EN
    tmo_d       = tmo_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start_frame) state_d = S_SETUP;
      end
      S_SETUP: begin
        px_d     = player_x;
        py_d     = player_y;
        alpha_d  = alpha_start_c;
        col_d    = '0;
        ray_to_d = 1'b0;
        state_d  = S_ISSUE;
      end
      S_ISSUE: begin
        // Found flags start cleared so an engine that never reports counts as a miss.
        h_done_d  = 1'b0;
        v_done_d  = 1'b0;
        h_found_d = 1'b0;
        v_found_d = 1'b0;
`ifdef RAYCAST_TIMEOUT_EN
        tmo_d     = '0;
`endif
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (h_end && !h_done_q) begin
          h_done_d  = 1'b1;
          h_found_d = h_found;
          h_wx_d    = h_wx;
          h_wy_d    = h_wy;
        end
        if (v_end && !v_done_q) begin
          v_done_d  = 1'b1;
          v_found_d = v_found;
          v_wx_d    = v_wx;
          v_wy_d    = v_wy;
        end
`ifdef RAYCAST_TIMEOUT_EN
        tmo_d = tmo_q + TW'(1);
`endif
        if (h_done_c && v_done_c) begin
          state_d = S_COMPARE;
        end else if (timeout_c) begin
          ray_to_d = 1'b1;
          state_d  = S_COMPARE;
        end
      end
      S_COMPARE: begin
        // Horizontal wins ties.
        if (h_found_q && (!v_found_q || (h_dist_c <= v_dist_c))) begin
          col_hit_d  = 1'b1;
          col_side_d = 1'b0;
          col_dist_d = h_dist_c;
          col_wx_d   = h_wx_q;
          col_wy_d   = h_wy_q;
        end else if (v_found_q) begin
          col_hit_d  = 1'b1;
          col_side_d = 1'b1;
          col_dist_d = v_dist_c;
          col_wx_d   = v_wx_q;
          col_wy_d   = v_wy_q;
        end else begin
          col_hit_d  = 1'b0;
          col_side_d = 1'b0;
          col_dist_d = NO_DIST;
          col_wx_d   = '0;
          col_wy_d   = '0;
        end
        col_valid_d = 1'b1;
        state_d     = S_OUTPUT;
      end
      S_OUTPUT: begin
        if (col_ready) begin
          col_valid_d = 1'b0;
          col_d       = col_q + CW'(1);
          alpha_d     = alpha_next_c;
          state_d     = (col_q == CW'(NUM_COLS - 1)) ? S_DONE : S_ISSUE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status strobes are decoded from the next state so they line up with the registered state.
    begin_calc_d = (state_d == S_ISSUE);
    frame_done_d = (state_d == S_DONE);
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      begin_calc_q <= 1'b0;
      px_q         <= '0;
      py_q         <= '0;
      alpha_q      <= '0;
      col_q        <= '0;
      h_done_q     <= 1'b0;
      v_done_q     <= 1'b0;
      h_found_q    <= 1'b0;
      v_found_q    <= 1'b0;
      h_wx_q       <= '0;
      h_wy_q       <= '0;
      v_wx_q       <= '0;
      v_wy_q       <= '0;
      col_valid_q  <= 1'b0;
      col_dist_q   <= '0;
      col_hit_q    <= 1'b0;
      col_side_q   <= 1'b0;
      col_wx_q     <= '0;
      col_wy_q     <= '0;
      ray_to_q     <= 1'b0;
`ifdef RAYCAST_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      begin_calc_q <= begin_calc_d;
      px_q         <= px_d;
      py_q         <= py_d;
      alpha_q      <= alpha_d;
      col_q        <= col_d;
      h_done_q     <= h_done_d;
      v_done_q     <= v_done_d;
      h_found_q    <= h_found_d;
      v_found_q    <= v_found_d;
      h_wx_q       <= h_wx_d;
      h_wy_q       <= h_wy_d;
      v_wx_q       <= v_wx_d;
      v_wy_q       <= v_wy_d;
      col_valid_q  <= col_valid_d;
      col_dist_q   <= col_dist_d;
      col_hit_q    <= col_hit_d;
      col_side_q   <= col_side_d;
      col_wx_q     <= col_wx_d;
      col_wy_q     <= col_wy_d;
      ray_to_q     <= ray_to_d;
`ifdef RAYCAST_TIMEOUT_EN
      tmo_q        <= tmo_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign begin_calc = begin_calc_q;
  assign ray_x      = px_q;
  assign ray_y      = py_q;
  assign ray_alpha  = alpha_q;
  assign col_valid  = col_valid_q;
  assign col_index  = col_q;
  assign col_dist   = col_dist_q;
  assign col_hit    = col_hit_q;
  assign col_side   = col_side_q;
  assign col_wx     = col_wx_q;
  assign col_wy     = col_wy_q;
`ifdef RAYCAST_TIMEOUT_EN
  assign ray_timeout = ray_to_q;
`else
  assign ray_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_raycast_column_scheduler.sv
// Directed bench for raycast_column_scheduler with a 4-column sweep and hand-computed records.
module tb_raycast_column_scheduler;

  localparam int unsigned NC = 4;

  logic        clock = 1'b0;
  logic        reset, start_frame, col_ready;
  logic [11:0] player_x, player_y, player_angle;
  logic        busy, frame_done, begin_calc, col_valid, col_hit, col_side, ray_timeout;
  logic [11:0] ray_x, ray_y, ray_alpha, col_wx, col_wy;
  logic        h_end, v_end, h_found, v_found;
  logic [11:0] h_wx, h_wy, v_wx, v_wy;
  logic [1:0]  col_index;
  logic [12:0] col_dist;

  int vectors = 0;
  int miscompares = 0;
  int fd_count = 0;

  always #10 clock = ~clock;

  always @(posedge clock) if (frame_done) fd_count++;

  raycast_column_scheduler #(.NUM_COLS(NC), .ANGLE_STEP(5), .ANGLE_FULL(3600)) dut (
    .clock(clock), .reset(reset), .start_frame(start_frame),
    .player_x(player_x), .player_y(player_y), .player_angle(player_angle),
    .busy(busy), .frame_done(frame_done), .ray_x(ray_x), .ray_y(ray_y),
    .ray_alpha(ray_alpha), .begin_calc(begin_calc),
    .h_end(h_end), .v_end(v_end), .h_found(h_found), .v_found(v_found),
    .h_wx(h_wx), .h_wy(h_wy), .v_wx(v_wx), .v_wy(v_wy),
    .col_valid(col_valid), .col_ready(col_ready), .col_index(col_index),
    .col_dist(col_dist), .col_hit(col_hit), .col_side(col_side),
    .col_wx(col_wx), .col_wy(col_wy), .ray_timeout(ray_timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic start(input int ang, input int px, input int py);
    @(posedge clock); #1;
    start_frame = 1'b1; player_angle = 12'(ang); player_x = 12'(px); player_y = 12'(py);
    @(posedge clock); #1;
    start_frame = 1'b0;
    check("busy_setup", busy, 1);
  endtask

  // One column: wait for begin_calc, pulse the engines, check the record, stall, accept.
  task automatic run_col(input int idx, input int alpha, input int dh, input int dv,
                         input logic hf, input int hx, input int hy,
                         input logic vf, input int vx, input int vy,
                         input logic ehit, input logic eside, input int edist,
                         input int ewx, input int ewy, input int stall, input int budget,
                         input bit midstart);
    int n;
    int last;
    n = 0;
    while (!begin_calc && n < 20) begin @(posedge clock); #1; n++; end
    check("begin_calc", begin_calc, 1);
    check("ray_alpha", ray_alpha, alpha);
    last = (dh > dv) ? dh : dv;
    for (int i = 1; i <= last; i++) begin
      @(posedge clock); #1;
      h_end = (i == dh); v_end = (i == dv);
      h_found = hf; h_wx = 12'(hx); h_wy = 12'(hy);
      v_found = vf; v_wx = 12'(vx); v_wy = 12'(vy);
      if (i == 1) check("begin_calc_pulse", begin_calc, 0);
    end
    @(posedge clock); #1;
    h_end = 1'b0; v_end = 1'b0;
    n = 0;
    while (!col_valid && n < budget) begin @(posedge clock); #1; n++; end
    check("col_valid", col_valid, 1);
    check("col_index", col_index, idx);
    check("col_hit", col_hit, ehit);
    check("col_side", col_side, eside);
    check("col_dist", col_dist, edist);
    check("col_wx", col_wx, ewx);
    check("col_wy", col_wy, ewy);
    for (int s = 0; s < stall; s++) begin
      @(posedge clock); #1;
      if (midstart) start_frame = (s == 2);
      check("stall_valid", col_valid, 1);
      check("stall_dist", col_dist, edist);
      check("stall_index", col_index, idx);
      check("stall_alpha", ray_alpha, alpha);
    end
    start_frame = 1'b0;
    col_ready = 1'b1;
    @(posedge clock); #1;
    col_ready = 1'b0;
    check("accept_drop", col_valid, 0);
  endtask

  initial begin
    reset = 1'b1; start_frame = 1'b0; col_ready = 1'b0;
    player_x = '0; player_y = '0; player_angle = '0;
    h_end = 1'b0; v_end = 1'b0; h_found = 1'b0; v_found = 1'b0;
    h_wx = '0; h_wy = '0; v_wx = '0; v_wy = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_col_valid", col_valid, 0);
    check("rst_ray_alpha", ray_alpha, 0);
    check("rst_begin_calc", begin_calc, 0);
    check("rst_col_dist", col_dist, 0);
    check("rst_ray_timeout", ray_timeout, 0);
    reset = 1'b0;

    // Frame 1: sweep from 0, nearest wall, tie, miss, v-only with negative deltas.
    start(10, 100, 100);
    run_col(0, 0,  3, 5, 1, 164, 100, 1, 100, 132, 1, 1, 32,   100, 132, 0, 20, 0);
    run_col(1, 5,  4, 4, 1, 140, 100, 1, 100, 60,  1, 0, 40,   140, 100, 7, 20, 1);
    run_col(2, 10, 6, 3, 0, 55,  77,  0, 33,  44,  0, 0, 8191, 0,   0,   0, 20, 0);
    run_col(3, 15, 3, 4, 0, 1,   2,   1, 90,  80,  1, 1, 30,   90,  80,  2, 20, 0);
    check("frame_done_pulse", frame_done, 1);
    @(posedge clock); #1;
    check("frame_done_low", frame_done, 0);
    check("busy_after_frame", busy, 0);
    check("fd_count_f1", fd_count, 1);

    // Frame 2: start angle wraps below zero.
    start(5, 200, 50);
    run_col(0, 3595, 3, 3, 1, 210, 50, 0, 0, 0, 1, 0, 10, 210, 50, 0, 20, 0);
    check("ray_x", ray_x, 200);
    check("ray_y", ray_y, 50);
    run_col(1, 0,  3, 3, 1, 190, 60, 0, 0, 0, 1, 0, 20, 190, 60, 0, 20, 0);
    run_col(2, 5,  5, 3, 1, 200, 40, 1, 205, 50, 1, 1, 5, 205, 50, 1, 20, 0);
    run_col(3, 10, 3, 3, 1, 201, 50, 1, 200, 51, 1, 0, 1, 201, 50, 0, 20, 0);
    check("frame_done_f2", frame_done, 1);
    @(posedge clock); #1;
    check("fd_count_f2", fd_count, 2);

    // Frame 3: reset during column 2 aborts without frame_done.
    start(100, 10, 10);
    run_col(0, 90, 3, 3, 1, 20, 10, 0, 0, 0, 1, 0, 10, 20, 10, 0, 20, 0);
    run_col(1, 95, 3, 3, 1, 20, 10, 0, 0, 0, 1, 0, 10, 20, 10, 0, 20, 0);
    begin
      int n;
      n = 0;
      while (!begin_calc && n < 20) begin @(posedge clock); #1; n++; end
    end
    check("col2_alpha", ray_alpha, 100);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_begin", begin_calc, 0);
    check("mid_rst_valid", col_valid, 0);
    check("mid_rst_alpha", ray_alpha, 0);
    check("mid_rst_ray_x", ray_x, 0);
    check("mid_rst_index", col_index, 0);
    check("mid_rst_dist", col_dist, 0);
    check("mid_rst_fd", frame_done, 0);
    repeat (6) @(posedge clock);
    #1;
    check("no_fd_after_rst", fd_count, 2);
    check("idle_after_rst", busy, 0);

`ifdef RAYCAST_TIMEOUT_EN
    // Vertical engine never reports: column comes from the h result after the wait limit.
    start(0, 0, 0);
    run_col(0, 3590, 3, 0, 1, 7, 9, 0, 0, 0, 1, 0, 16, 7, 9, 0, 1100, 0);
    check("ray_timeout", ray_timeout, 1);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("timeout_cleared", ray_timeout, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
